// File: rtl/lc3b_defs.sv
// Shared definitions for the LC-3b memory port arbiter: state encodings,
// default access latency and byte-lane helpers.
package lc3b_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } arb_state_e;

  localparam int unsigned MEM_LATENCY_DEF = 5;
  localparam logic [15:0] WORD_MASK       = 16'hFFFE;

  // Write-lane enables {hi,lo} for a data store.
  function automatic logic [1:0] byte_lanes(input logic is_byte, input logic a0);
    if (!is_byte) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Access latency down-counter: loaded on entry to a busy state, flags the
// final cycle of the access when it reaches zero.
module mem_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access;
// data has strict priority, each access holds the port for MEM_LATENCY cycles.
module mem_arbiter
  import lc3b_defs::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_abort,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_byte,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        if_rdy,
  output logic [15:0] if_instr,
  output logic        dm_rdy,
  output logic [15:0] dm_rdata,
  output logic        mem_stall
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  arb_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic        mem_en_q, mem_en_d;
  logic [1:0]  mem_we_q, mem_we_d;
  logic        cnt_load;
  logic        cnt_zero;
  logic [15:0] rd_sel;

  mem_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_M1),
    .en       (state_q != ST_IDLE),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    byte_d   = byte_q;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_req) begin
          state_d  = ST_DBUSY;
          cnt_load = 1'b1;
          addr_d   = dm_byte ? dm_addr : (dm_addr & WORD_MASK);
          wdata_d  = dm_byte ? {2{dm_wdata[7:0]}} : dm_wdata;
          we_d     = dm_we;
          byte_d   = dm_byte;
        end else if (if_req && !if_abort) begin
          state_d  = ST_IBUSY;
          cnt_load = 1'b1;
          addr_d   = if_addr & WORD_MASK;
          wdata_d  = 16'h0000;
          we_d     = 1'b0;
          byte_d   = 1'b0;
        end
      end
      // A redirect kills the fetch even on its final cycle.
      ST_IBUSY: if (if_abort || cnt_zero) state_d = ST_IDLE;
      ST_DBUSY: if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    mem_en_d = (state_d != ST_IDLE);
    mem_we_d = (state_d == ST_DBUSY && we_d) ? byte_lanes(byte_d, addr_d[0]) : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
    end
  end

  assign rd_sel = byte_q ? {8'h00, (addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0])}
                         : mem_rdata;

  assign if_rdy    = (state_q == ST_IBUSY) && cnt_zero && !if_abort;
  assign if_instr  = if_rdy ? mem_rdata : 16'h0000;
  assign dm_rdy    = (state_q == ST_DBUSY) && cnt_zero;
  assign dm_rdata  = (dm_rdy && !we_q) ? rd_sel : 16'h0000;
  assign mem_stall = dm_req && !dm_rdy;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 5 and 1), a transaction-level
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int LAT0 = 5;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        if_req[2], if_abort[2], dm_req[2], dm_we[2], dm_byte[2];
  logic [15:0] if_addr[2], dm_addr[2], dm_wdata[2], mem_rdata[2];
  logic        mem_en[2], if_rdy[2], dm_rdy[2], mem_stall[2];
  logic [1:0]  mem_we[2];
  logic [15:0] mem_addr[2], mem_wdata[2], if_instr[2], dm_rdata[2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_abort(if_abort[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_byte(dm_byte[0]),
    .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .if_rdy(if_rdy[0]), .if_instr(if_instr[0]),
    .dm_rdy(dm_rdy[0]), .dm_rdata(dm_rdata[0]), .mem_stall(mem_stall[0])
  );

  mem_arbiter #(.MEM_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_abort(if_abort[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_byte(dm_byte[1]),
    .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .if_rdy(if_rdy[1]), .if_instr(if_instr[1]),
    .dm_rdy(dm_rdy[1]), .dm_rdata(dm_rdata[1]), .mem_stall(mem_stall[1])
  );

  task automatic chk(input string name, input int inst,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t: got %h, expected %h", name, inst, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // Model: an access accepted in idle cycle S occupies cycles S+1..S+L and
  // completes in cycle S+L.
  bit          m_busy[2];
  bit          m_data[2];
  bit          m_we[2];
  bit          m_byte[2];
  logic [15:0] m_addr[2];
  logic [15:0] m_wd[2];
  int          m_start[2];
  int          cyc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) m_busy[i] <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          if (cyc == m_start[i] + lat_of(i) || (!m_data[i] && if_abort[i]))
            m_busy[i] <= 1'b0;
        end else if (dm_req[i]) begin
          m_busy[i]  <= 1'b1;
          m_data[i]  <= 1'b1;
          m_we[i]    <= dm_we[i];
          m_byte[i]  <= dm_byte[i];
          m_addr[i]  <= dm_byte[i] ? dm_addr[i] : {dm_addr[i][15:1], 1'b0};
          m_wd[i]    <= dm_byte[i] ? {dm_wdata[i][7:0], dm_wdata[i][7:0]} : dm_wdata[i];
          m_start[i] <= cyc;
        end else if (if_req[i] && !if_abort[i]) begin
          m_busy[i]  <= 1'b1;
          m_data[i]  <= 1'b0;
          m_we[i]    <= 1'b0;
          m_byte[i]  <= 1'b0;
          m_addr[i]  <= {if_addr[i][15:1], 1'b0};
          m_start[i] <= cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        fin, e_ifr, e_dmr;
      logic [1:0]  e_we;
      logic [15:0] rd, e_dmd;
      rd    = mem_rdata[i];
      fin   = m_busy[i] && (cyc == m_start[i] + lat_of(i));
      e_we  = (m_busy[i] && m_data[i] && m_we[i]) ?
              (m_byte[i] ? (m_addr[i][0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
      e_ifr = m_busy[i] && !m_data[i] && fin && !if_abort[i];
      e_dmr = m_busy[i] && m_data[i] && fin;
      e_dmd = (e_dmr && !m_we[i]) ?
              (m_byte[i] ? {8'h00, (m_addr[i][0] ? rd[15:8] : rd[7:0])} : rd) : 16'h0000;
      chk("m_mem_en",   i, 16'(mem_en[i]),    16'(m_busy[i]));
      chk("m_mem_we",   i, 16'(mem_we[i]),    16'(e_we));
      chk("m_if_rdy",   i, 16'(if_rdy[i]),    16'(e_ifr));
      chk("m_if_instr", i, if_instr[i],       e_ifr ? rd : 16'h0000);
      chk("m_dm_rdy",   i, 16'(dm_rdy[i]),    16'(e_dmr));
      chk("m_dm_rdata", i, dm_rdata[i],       e_dmd);
      chk("m_stall",    i, 16'(mem_stall[i]), 16'(dm_req[i] && !e_dmr));
      if (m_busy[i]) chk("m_mem_addr", i, mem_addr[i], m_addr[i]);
      if (m_busy[i] && m_data[i]) chk("m_mem_wdata", i, mem_wdata[i], m_wd[i]);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_abort[i] = 1'b0; dm_req[i] = 1'b0;
      dm_we[i] = 1'b0; dm_byte[i] = 1'b0;
      if_addr[i] = 16'h0000; dm_addr[i] = 16'h0000;
      dm_wdata[i] = 16'h0000; mem_rdata[i] = 16'h0000;
    end
  endtask

  initial begin
    clr_inputs();
    #2 reset = 1'b1;
    #10;
    for (int i = 0; i < 2; i++) begin
      chk("rst_en",    i, 16'(mem_en[i]), 16'h0);
      chk("rst_we",    i, 16'(mem_we[i]), 16'h0);
      chk("rst_addr",  i, mem_addr[i],    16'h0000);
      chk("rst_wdata", i, mem_wdata[i],   16'h0000);
      chk("rst_ifrdy", i, 16'(if_rdy[i]), 16'h0);
      chk("rst_dmrdy", i, 16'(dm_rdy[i]), 16'h0);
    end
    #10 reset = 1'b0;

    // Plain fetch, latency 5
    adv(); if_req[0] = 1'b1; if_addr[0] = 16'h3000; mem_rdata[0] = 16'h1234;
    smp(); chk("t1_en_c0", 0, 16'(mem_en[0]), 16'h0);
    for (int k = 1; k <= 5; k++) begin
      adv();
      if (k == 1) begin if_req[0] = 1'b0; if_addr[0] = 16'h5555; end
      smp();
      chk("t1_en",    0, 16'(mem_en[0]), 16'h1);
      chk("t1_addr",  0, mem_addr[0],    16'h3000);
      chk("t1_ifrdy", 0, 16'(if_rdy[0]), 16'(k == 5));
      if (k == 5) chk("t1_instr", 0, if_instr[0], 16'h1234);
    end
    adv(); smp();
    chk("t1_en_after", 0, 16'(mem_en[0]), 16'h0);
    chk("t1_rdy_after", 0, 16'(if_rdy[0]), 16'h0);

    // Simultaneous data read and fetch; abort ignored on data
    adv();
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_byte[0] = 1'b0; dm_addr[0] = 16'h4000;
    if_req[0] = 1'b1; if_addr[0] = 16'h3002; if_abort[0] = 1'b1; mem_rdata[0] = 16'h5678;
    smp(); chk("t2_stall_c0", 0, 16'(mem_stall[0]), 16'h1);
    for (int k = 1; k <= 11; k++) begin
      adv();
      if_abort[0] = (k == 3);
      if (k == 6) dm_req[0] = 1'b0;
      if (k == 7) begin if_req[0] = 1'b0; mem_rdata[0] = 16'h9ABC; end
      smp();
      if (k <= 4) chk("t2_stall", 0, 16'(mem_stall[0]), 16'h1);
      if (k <= 5) chk("t2_addr", 0, mem_addr[0], 16'h4000);
      if (k == 5) begin
        chk("t2_dmrdy", 0, 16'(dm_rdy[0]), 16'h1);
        chk("t2_dmrdata", 0, dm_rdata[0], 16'h5678);
        chk("t2_stall_c5", 0, 16'(mem_stall[0]), 16'h0);
      end
      if (k == 6) chk("t2_gap", 0, 16'(mem_en[0]), 16'h0);
      if (k >= 7) chk("t2_ifrdy", 0, 16'(if_rdy[0]), 16'(k == 11));
      if (k == 11) chk("t2_instr", 0, if_instr[0], 16'h9ABC);
    end

    // Byte write then byte read of 0x4001
    adv();
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_byte[0] = 1'b1;
    dm_addr[0] = 16'h4001; dm_wdata[0] = 16'h00AB; mem_rdata[0] = 16'h0000;
    smp();
    for (int k = 1; k <= 12; k++) begin
      adv();
      if (k == 6) begin dm_we[0] = 1'b0; dm_wdata[0] = 16'hFFFF; mem_rdata[0] = 16'hAB00; end
      if (k == 12) dm_req[0] = 1'b0;
      smp();
      if (k <= 5) begin
        chk("t3_we",    0, 16'(mem_we[0]), 16'h2);
        chk("t3_wdata", 0, mem_wdata[0],   16'hABAB);
        chk("t3_addr",  0, mem_addr[0],    16'h4001);
      end
      if (k == 5) chk("t3_wrdy", 0, 16'(dm_rdy[0]), 16'h1);
      if (k == 6) chk("t3_gap", 0, 16'(mem_en[0]), 16'h0);
      if (k >= 7 && k <= 11) chk("t3_rd_we", 0, 16'(mem_we[0]), 16'h0);
      if (k == 11) begin
        chk("t3_rrdy", 0, 16'(dm_rdy[0]), 16'h1);
        chk("t3_rdata", 0, dm_rdata[0], 16'h00AB);
      end
    end

    // Fetch aborted in busy cycle 3
    adv(); if_req[0] = 1'b1; if_addr[0] = 16'h3004; mem_rdata[0] = 16'h1111;
    smp();
    for (int k = 1; k <= 5; k++) begin
      adv();
      if (k == 1) if_req[0] = 1'b0;
      if_abort[0] = (k == 3);
      smp();
      if (k == 3) chk("t4a_ifrdy", 0, 16'(if_rdy[0]), 16'h0);
      if (k >= 4) chk("t4a_en", 0, 16'(mem_en[0]), 16'h0);
    end
    // Fetch aborted on its final cycle
    adv(); if_req[0] = 1'b1; mem_rdata[0] = 16'h7777;
    smp();
    for (int k = 1; k <= 6; k++) begin
      adv();
      if (k == 1) if_req[0] = 1'b0;
      if_abort[0] = (k == 5);
      smp();
      if (k == 5) begin
        chk("t4b_ifrdy", 0, 16'(if_rdy[0]), 16'h0);
        chk("t4b_instr", 0, if_instr[0], 16'h0000);
        chk("t4b_en", 0, 16'(mem_en[0]), 16'h1);
      end
      if (k == 6) chk("t4b_en_after", 0, 16'(mem_en[0]), 16'h0);
    end

    // Reset in busy cycle 2 of a word write
    adv();
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_byte[0] = 1'b0;
    dm_addr[0] = 16'h4002; dm_wdata[0] = 16'hBEEF;
    smp();
    adv(); smp(); chk("t5_we_c1", 0, 16'(mem_we[0]), 16'h3);
    adv();
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_en",    0, 16'(mem_en[0]), 16'h0);
    chk("t5_rst_we",    0, 16'(mem_we[0]), 16'h0);
    chk("t5_rst_dmrdy", 0, 16'(dm_rdy[0]), 16'h0);
    chk("t5_rst_addr",  0, mem_addr[0],    16'h0000);
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    smp();
    adv();
    #2 reset = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 16'h3006; mem_rdata[0] = 16'h4321;
    for (int k = 1; k <= 5; k++) begin
      adv();
      if (k == 1) if_req[0] = 1'b0;
      smp();
      chk("t5_ifrdy", 0, 16'(if_rdy[0]), 16'(k == 5));
      if (k == 5) chk("t5_instr", 0, if_instr[0], 16'h4321);
    end

    // Latency 1: alternating data reads and fetches
    for (int k = 0; k < 12; k++) begin
      adv();
      case (k % 4)
        0: begin dm_req[1] = 1'b1; dm_addr[1] = 16'h0010 + 16'(k); mem_rdata[1] = 16'h0A00 + 16'(k); end
        2: begin dm_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 16'h2000 + 16'(k); end
        3: if_req[1] = 1'b0;
        default: ;
      endcase
      smp();
      chk("t6_en", 1, 16'(mem_en[1]), 16'(k % 2));
      chk("t6_dmrdy", 1, 16'(dm_rdy[1]), 16'((k % 4) == 1));
      chk("t6_ifrdy", 1, 16'(if_rdy[1]), 16'((k % 4) == 3));
      if ((k % 4) == 1) chk("t6_dmrdata", 1, dm_rdata[1], 16'h0A00 + 16'(k - 1));
      if ((k % 4) == 3) chk("t6_instr", 1, if_instr[1], 16'h0A00 + 16'(k - 3));
    end

    adv(); clr_inputs();
    adv(); adv(); smp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 5: cycles each memory access occupies the port; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch stage requests an instruction read.
REQ-005 if_addr  in  16  fetch address (PC).
REQ-006 if_abort  in  1  redirect/flush (nonzero PC mux select); kills an in-flight fetch.
REQ-007 dm_req  in  1  memory stage requests a data access.
REQ-008 dm_we  in  1  1 = write, 0 = read.
REQ-009 dm_byte  in  1  1 = byte access, 0 = word access.
REQ-010 dm_addr  in  16  data address.
REQ-011 dm_wdata  in  16  write data; a byte write uses bits [7:0].
REQ-012 mem_rdata  in  16  memory array read data, valid on the final cycle of an access.
REQ-013 mem_en  out  1  memory access enable.
REQ-014 mem_we  out  2  byte write enables {hi,lo}.
REQ-015 mem_addr  out  16  latched access address.
REQ-016 mem_wdata  out  16  latched write data.
REQ-017 if_rdy  out  1  fetch complete; drives imem_r.
REQ-018 if_instr  out  16  fetched instruction, valid while if_rdy = 1.
REQ-019 dm_rdy  out  1  data access complete.
REQ-020 dm_rdata  out  16  read data, valid while dm_rdy = 1; a byte read is zero-extended.
REQ-021 mem_stall  out  1  = dm_req & ~dm_rdy.

Function
REQ-022 The FSM SHALL have states IDLE, IBUSY and DBUSY, plus a 4-bit down-counter cnt.
- IDLE: dm_req -> DBUSY; else if_req & ~if_abort -> IBUSY.
- On entering a busy state: cnt = MEM_LATENCY-1; address, we, byte and wdata are latched.
REQ-023 Data SHALL have strict priority over fetch; when both requests arrive in the same IDLE cycle, the data access goes first.
REQ-024 In a busy state, cnt SHALL decrement each cycle.
- The final cycle is cnt == 0: assert the rdy of the owning requester for exactly 1 cycle, then go to IDLE.
REQ-025 Latency: rdy SHALL assert exactly MEM_LATENCY cycles after the IDLE cycle in which the request was accepted.
- A 1-cycle IDLE gap separates back-to-back accesses.
REQ-026 mem_en SHALL be 1 in every busy cycle and 0 in IDLE; mem_addr and mem_wdata SHALL hold their latched values throughout the access.
REQ-027 mem_we SHALL be nonzero only in DBUSY with dm_we = 1.
- Word access: 2'b11.
- Byte access: 2'b10 if addr[0] = 1, else 2'b01; dm_wdata[7:0] is replicated onto both lanes.
REQ-028 Word accesses SHALL ignore addr[0].
REQ-029 Byte reads SHALL select mem_rdata[15:8] when addr[0] = 1, otherwise [7:0].
REQ-030 if_abort in IBUSY SHALL force IDLE next cycle with no if_rdy; it applies on any cycle including cnt == 0, where it wins and if_rdy stays 0.
REQ-031 if_abort SHALL have no effect on DBUSY or on an IDLE data grant.
REQ-032 if_rdy and if_instr SHALL be 0 outside the completing IBUSY cycle; dm_rdy and dm_rdata SHALL be 0 outside the completing DBUSY cycle.
REQ-033 Requests SHALL be sampled only in IDLE; changes to a request's inputs during a busy state are ignored.

Reset
REQ-034 Reset SHALL force IDLE and cnt = 0 immediately, with all outputs 0, mem_addr and mem_wdata cleared to 16'h0000.
REQ-035 Reset mid-access SHALL drop the access with no rdy pulse and deassert mem_we immediately.
REQ-036 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-037 The state encodings (IDLE = 0, IBUSY = 1, DBUSY = 2) and the default MEM_LATENCY SHALL live in the shared lc3b_defs header.
REQ-038 The latency counter SHALL be a sub-module, mem_lat_counter, with inputs load, load value and enable, and output zero.

Verification
REQ-039 MEM_LATENCY = 5; fetch of 16'h3000 with mem_rdata = 16'h1234 -> mem_en for 5 cycles, if_rdy pulses in cycle 5 with if_instr = 16'h1234.
REQ-040 dm_req (read, addr 16'h4000) and if_req asserted together -> data served first, dm_rdy at cycle 5, then 1 IDLE cycle, then fetch if_rdy at cycle 11; mem_stall = 1 in cycles 0-4.
REQ-041 Byte write of dm_wdata = 16'h00AB to 16'h4001 -> mem_we = 2'b10 and mem_wdata = 16'hABAB for 5 cycles; byte read of the same address with mem_rdata = 16'hAB00 -> dm_rdata = 16'h00AB.
REQ-042 if_abort in busy cycle 3 of a fetch -> IDLE next cycle, no if_rdy; if_abort on the cnt == 0 cycle -> if_rdy stays 0.
REQ-043 Reset asserted in busy cycle 2 of a write -> mem_en = 0 and mem_we = 0 immediately, no dm_rdy; after release, a new fetch completes in 5 cycles.
REQ-044 MEM_LATENCY = 1 -> rdy in the cycle after acceptance; alternating requests each complete every 2 cycles.
